// File: rtl/issue_select_rr.sv
// Round-robin issue selector: picks one ready issue-queue slot per cycle and
// presents it as a registered one-hot grant under a valid/ready handshake.
module issue_select_rr #(
  parameter int SEL_WIDTH     = 32,
  parameter int SEL_WIDTH_LOG = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [SEL_WIDTH-1:0] req_i,
  input  logic                 flush_i,
  input  logic                 grant_ready_i,
  output logic                 grant_valid_o,
  output logic [SEL_WIDTH-1:0] grant_o
);

  logic                     valid_reg;
  logic [SEL_WIDTH-1:0]     grant_reg;
  logic [SEL_WIDTH_LOG-1:0] ptr_reg;
  logic [SEL_WIDTH_LOG-1:0] ptr_next;
  logic [SEL_WIDTH_LOG-1:0] grant_idx;
  logic [SEL_WIDTH_LOG-1:0] sel_off;
  logic [SEL_WIDTH_LOG-1:0] sel_idx;
  logic [SEL_WIDTH-1:0]     cand;
  logic [SEL_WIDTH-1:0]     rot;
  logic [SEL_WIDTH-1:0]     grant_next;
  logic                     acc;
  logic                     load;
  logic                     cand_any;

  assign acc  = valid_reg & grant_ready_i;
  assign load = ~flush_i & (~valid_reg | acc);

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < SEL_WIDTH; i++) begin
      if (grant_reg[i]) grant_idx = grant_idx | i[SEL_WIDTH_LOG-1:0];
    end
  end

  assign ptr_next = acc ? grant_idx + SEL_WIDTH_LOG'(1) : ptr_reg;

  // The slot being handed off is masked: the queue only clears it next cycle.
  assign cand = req_i & ~(acc ? grant_reg : '0);

  // Rotate so that bit 0 of rot is the slot at ptr_next; wrap is free since
  // SEL_WIDTH is a power of two.
  genvar gi;
  generate
    for (gi = 0; gi < SEL_WIDTH; gi++) begin : g_rot
      logic [SEL_WIDTH_LOG-1:0] src;
      assign src     = ptr_next + SEL_WIDTH_LOG'(gi);
      assign rot[gi] = cand[src];
    end
  endgenerate

  always_comb begin
    sel_off = '0;
    for (int i = SEL_WIDTH - 1; i >= 0; i--) begin
      if (rot[i]) sel_off = i[SEL_WIDTH_LOG-1:0];
    end
  end

  assign cand_any   = |cand;
  assign sel_idx    = ptr_next + sel_off;
  assign grant_next = cand_any ? (SEL_WIDTH'(1) << sel_idx) : '0;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_reg <= 1'b0;
      grant_reg <= '0;
      ptr_reg   <= '0;
    end else begin
      ptr_reg <= ptr_next;
      if (flush_i) begin
        valid_reg <= 1'b0;
        grant_reg <= '0;
      end else if (load) begin
        valid_reg <= cand_any;
        grant_reg <= grant_next;
      end
    end
  end

  assign grant_valid_o = valid_reg;
  assign grant_o       = grant_reg;

endmodule

// File: tb/tb_issue_select_rr.sv
// Self-checking bench for issue_select_rr: directed scenarios followed by a
// randomized run, all compared against a slot-index reference model.
module tb_issue_select_rr;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n_i;
  logic [W-1:0] req_i;
  logic         flush_i;
  logic         grant_ready_i;
  logic         grant_valid_o;
  logic [W-1:0] grant_o;

  int total = 0;
  int bad   = 0;

  // reference model state: valid flag, granted slot number, pointer slot
  bit m_valid;
  int m_idx;
  int m_ptr;

  issue_select_rr #(.SEL_WIDTH(W), .SEL_WIDTH_LOG(5)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n_i),
    .req_i         (req_i),
    .flush_i       (flush_i),
    .grant_ready_i (grant_ready_i),
    .grant_valid_o (grant_valid_o),
    .grant_o       (grant_o)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_valid = 1'b0;
    m_idx   = 0;
    m_ptr   = 0;
  endtask

  task automatic model_update(input logic [W-1:0] req, input bit ready, input bit flush);
    bit acc;
    int ptr_n;
    int pick;
    acc   = m_valid && ready;
    ptr_n = acc ? (m_idx + 1) % W : m_ptr;
    pick  = -1;
    for (int k = 0; k < W; k++) begin
      int slot;
      slot = (ptr_n + k) % W;
      if (pick < 0 && req[slot] && !(acc && slot == m_idx)) pick = slot;
    end
    if (flush) begin
      m_valid = 1'b0;
    end else if (!m_valid || acc) begin
      m_valid = (pick >= 0);
      if (pick >= 0) m_idx = pick;
    end
    m_ptr = ptr_n;
  endtask

  task automatic check_lit(input string tag, input logic ev, input logic [W-1:0] eg);
    total++;
    assert ({grant_valid_o, grant_o} === {ev, eg}) else begin
      bad++;
      $error("FAIL %s: observed valid=%0b grant=%h, expected valid=%0b grant=%h",
             tag, grant_valid_o, grant_o, ev, eg);
    end
  endtask

  task automatic check_model(input string tag);
    logic [W-1:0] eg;
    eg = m_valid ? (32'h1 << m_idx) : '0;
    total++;
    assert ({grant_valid_o, grant_o} === {m_valid, eg}) else begin
      bad++;
      $error("FAIL %s: observed valid=%0b grant=%h, model valid=%0b grant=%h",
             tag, grant_valid_o, grant_o, m_valid, eg);
    end
  endtask

  task automatic check_ptr(input string tag, input int ep);
    logic [4:0] e5;
    e5 = ep[4:0];
    total++;
    assert (dut.ptr_reg === e5) else begin
      bad++;
      $error("FAIL %s: observed ptr=%0d expected ptr=%0d", tag, dut.ptr_reg, e5);
    end
  endtask

  task automatic check_inv(input string tag);
    total++;
    assert (($countones(grant_o) <= 1) && ((grant_o != '0) === grant_valid_o)) else begin
      bad++;
      $error("FAIL %s: invariant broken valid=%0b grant=%h", tag, grant_valid_o, grant_o);
    end
  endtask

  // drive inputs right after a falling edge, model the rising edge, sample at the next falling edge
  task automatic step(input logic [W-1:0] req, input bit ready, input bit flush);
    req_i         = req;
    grant_ready_i = ready;
    flush_i       = flush;
    @(posedge clk);
    model_update(req, ready, flush);
    @(negedge clk);
    $display("step req=%h rdy=%0b fl=%0b -> valid=%0b grant=%h", req, ready, flush,
             grant_valid_o, grant_o);
    check_model("model");
    check_inv("inv");
  endtask

  initial begin
    rst_n_i       = 1'b0;
    req_i         = '1;
    flush_i       = 1'b0;
    grant_ready_i = 1'b0;
    model_reset();

    // reset held with all requests up
    repeat (3) @(negedge clk);
    check_lit("rst_hold", 1'b0, 32'h0);
    check_ptr("rst_ptr", 0);
    rst_n_i = 1'b1;
    req_i   = '0;
    for (int i = 0; i < 3; i++) begin
      step(32'h0, 1'b1, 1'b0);
      check_lit("idle_after_rst", 1'b0, 32'h0);
    end
    step(32'h1, 1'b1, 1'b0);
    check_lit("first_grant", 1'b1, 32'h1);
    step(32'h0, 1'b1, 1'b0);
    check_lit("drain0", 1'b0, 32'h0);
    check_ptr("ptr_after_first", 1);

    // alternation between slots 2 and 4
    step(32'h14, 1'b1, 1'b0); check_lit("alt0", 1'b1, 32'h04);
    step(32'h14, 1'b1, 1'b0); check_lit("alt1", 1'b1, 32'h10);
    step(32'h14, 1'b1, 1'b0); check_lit("alt2", 1'b1, 32'h04);
    step(32'h14, 1'b1, 1'b0); check_lit("alt3", 1'b1, 32'h10);
    step(32'h0, 1'b1, 1'b0);  check_lit("alt_drain", 1'b0, 32'h0);
    check_ptr("ptr_after_alt", 5);

    // wrap-around past slot 31
    step(32'h4000_0000, 1'b1, 1'b0); check_lit("wrap_b30", 1'b1, 32'h4000_0000);
    step(32'h8000_0001, 1'b1, 1'b0); check_lit("wrap_b31", 1'b1, 32'h8000_0000);
    check_ptr("ptr_31", 31);
    step(32'h8000_0001, 1'b1, 1'b0); check_lit("wrap_b0", 1'b1, 32'h0000_0001);
    check_ptr("ptr_wrapped", 0);
    step(32'h8000_0001, 1'b1, 1'b0); check_lit("wrap_b31b", 1'b1, 32'h8000_0000);
    step(32'h0, 1'b1, 1'b0);         check_lit("wrap_drain", 1'b0, 32'h0);

    // backpressure: grant frozen while requests change
    step(32'h04, 1'b0, 1'b0); check_lit("bp_grant", 1'b1, 32'h04);
    for (int i = 0; i < 3; i++) begin
      step(32'h100, 1'b0, 1'b0);
      check_lit("bp_hold", 1'b1, 32'h04);
      check_ptr("bp_ptr", 0);
    end
    step(32'h100, 1'b1, 1'b0); check_lit("bp_release", 1'b1, 32'h100);
    step(32'h0, 1'b1, 1'b0);   check_lit("bp_drain", 1'b0, 32'h0);

    // flush coinciding with an accept still advances the pointer
    step(32'h04, 1'b0, 1'b0); check_lit("fl_setup", 1'b1, 32'h04);
    step(32'h14, 1'b1, 1'b1); check_lit("fl_cleared", 1'b0, 32'h0);
    check_ptr("fl_ptr", 3);
    step(32'h14, 1'b1, 1'b0); check_lit("fl_next", 1'b1, 32'h10);

    // asynchronous reset between edges
    rst_n_i = 1'b0;
    #1;
    check_lit("async_rst", 1'b0, 32'h0);
    check_ptr("async_ptr", 0);
    #1;
    rst_n_i = 1'b1;
    model_reset();
    step(32'h14, 1'b1, 1'b0); check_lit("post_async", 1'b1, 32'h04);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] r;
      r = (i % 50 < 5) ? '0 : ($urandom() & $urandom());
      step(r, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
